// File: rtl/uart_wb_bridge_if.sv
// uart_wb_bridge_if: byte-stream and Wishbone signals of the debug bridge
// master: bridge side (drives tx_* and wb_* requests); slave: UART/bus environment side.
interface uart_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic wb_we;
  logic [3:0] wb_sel;
  logic wb_stb;
  logic wb_cyc;
  logic wb_ack;
  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack,
    output tx_data, tx_valid, wb_addr, wb_dat_o, wb_we, wb_sel, wb_stb, wb_cyc
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack,
    input  tx_data, tx_valid, wb_addr, wb_dat_o, wb_we, wb_sel, wb_stb, wb_cyc
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART byte-stream debug bridge issuing one Wishbone classic transfer per frame
// Ports: clk; rst_n async active-low; bus.rx_* command bytes in; bus.tx_* status/data bytes out;
//        bus.wb_* Wishbone initiator; busy = not idle; overrun = sticky dropped-byte flag.
module uart_wb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_TIMEOUT = 1024,
  parameter int FRAME_TIMEOUT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  uart_wb_bridge_if.master bus,
  output logic busy,
  output logic overrun
);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [FW-1:0] FT_LAST = FW'(FRAME_TIMEOUT - 1);
  localparam logic [BW-1:0] BT_LAST = BW'(BUS_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS, RESP_STATUS, RESP_DATA} state_t;
  state_t state, state_d;
  logic we, we_d;
  logic [1:0] cnt, cnt_d;
  logic [31:0] addr, addr_d, wdata, wdata_d, rdata, rdata_d;
  logic [7:0] status, status_d;
  logic [FW-1:0] ft, ft_d;
  logic [BW-1:0] bt, bt_d;
  logic rx_ok, ovr_d, stb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      we <= 1'b0;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      status <= '0;
      ft <= '0;
      bt <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      we <= we_d;
      cnt <= cnt_d;
      addr <= addr_d;
      wdata <= wdata_d;
      rdata <= rdata_d;
      status <= status_d;
      ft <= ft_d;
      bt <= bt_d;
      overrun <= ovr_d;
    end
  always_comb begin
    state_d = state;
    we_d = we;
    cnt_d = cnt;
    addr_d = addr;
    wdata_d = wdata;
    rdata_d = rdata;
    status_d = status;
    ft_d = ft;
    bt_d = bt;
    rx_ok = state == IDLE || state == GET_ADDR || state == GET_DATA;
    ovr_d = overrun | (bus.rx_valid & ~rx_ok);
    case (state)
      IDLE:
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_W || bus.rx_data == CMD_R) begin
            we_d = bus.rx_data == CMD_W;
            cnt_d = '0;
            ft_d = '0;
            state_d = GET_ADDR;
          end else begin
            status_d = NAK;
            state_d = RESP_STATUS;
          end
        end
      GET_ADDR, GET_DATA:
        if (bus.rx_valid) begin
          ft_d = '0;
          cnt_d = cnt + 2'd1;
          if (state == GET_ADDR) addr_d = {addr[23:0], bus.rx_data};
          else wdata_d = {wdata[23:0], bus.rx_data};
          if (cnt == 2'd3) begin
            bt_d = '0;
            state_d = state == GET_ADDR && we ? GET_DATA : BUS;
          end
        end else if (ft == FT_LAST) begin
          state_d = IDLE;
        end else begin
          ft_d = ft + FW'(1);
        end
      BUS:
        // ack is checked first so an ack in the expiry cycle still wins
        if (bus.wb_ack) begin
          if (!we) rdata_d = bus.wb_dat_i;
          status_d = ACK;
          state_d = RESP_STATUS;
        end else if (bt == BT_LAST) begin
          status_d = NAK;
          state_d = RESP_STATUS;
        end else begin
          bt_d = bt + BW'(1);
        end
      RESP_STATUS:
        if (bus.tx_ready) begin
          cnt_d = '0;
          state_d = status == ACK && !we ? RESP_DATA : IDLE;
        end
      RESP_DATA:
        // rdata shifts so the byte on the wire is always rdata[31:24]
        if (bus.tx_ready) begin
          rdata_d = rdata << 8;
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  assign stb = state == BUS;
  assign bus.wb_stb = stb;
  assign bus.wb_cyc = stb;
  assign bus.wb_sel = {4{stb}};
  assign bus.wb_we = stb & we;
  assign bus.wb_addr = addr[ADDR_WIDTH-1:0];
  assign bus.wb_dat_o = wdata;
  assign bus.tx_valid = state == RESP_STATUS || state == RESP_DATA;
  assign bus.tx_data = state == RESP_STATUS ? status : rdata[31:24];
  assign busy = state != IDLE;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: randomized frame-level check of uart_wb_bridge against a queue-based model
module tb_uart_wb_bridge;
  localparam int BT = 16;
  localparam int FT = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy, overrun;
  uart_wb_bridge_if #(.ADDR_WIDTH(32)) bus ();
  uart_wb_bridge #(.ADDR_WIDTH(32), .BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic we;
    logic [31:0] d;
    bit noack;
  } xfer_t;
  xfer_t exp_bus[$];
  xfer_t got_bus[$];
  xfer_t cur;
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  int lat_q[$];
  logic [31:0] smem [8];
  logic [31:0] mmem [8];
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int cyc_n = 0;
  int slv_cnt = -1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_byte(logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask
  // lat < 0 means the slave never acks; otherwise ack appears lat cycles after stb rises
  task automatic send_frame(logic we, logic [31:0] a, logic [31:0] d, int lat, int gmax);
    logic [7:0] b[$];
    logic [31:0] r;
    xfer_t x;
    x.a = a;
    x.we = we;
    x.d = d;
    x.noack = lat < 0;
    exp_bus.push_back(x);
    lat_q.push_back(lat < 0 ? 1000 : lat);
    if (lat < 0) exp_tx.push_back(8'h15);
    else if (we) begin
      exp_tx.push_back(8'h06);
      mmem[a[4:2]] = d;
    end else begin
      r = mmem[a[4:2]];
      exp_tx.push_back(8'h06);
      for (int k = 3; k >= 0; k--) exp_tx.push_back(r[8*k +: 8]);
    end
    b.push_back(we ? 8'h57 : 8'h52);
    for (int k = 3; k >= 0; k--) b.push_back(a[8*k +: 8]);
    if (we) for (int k = 3; k >= 0; k--) b.push_back(d[8*k +: 8]);
    for (int k = 0; k < b.size(); k++) begin
      send_byte(b[k]);
      if (k != b.size() - 1) tick($urandom_range(0, gmax));
    end
  endtask
  task automatic wait_idle();
    int i = 0;
    while ((exp_tx.size() != 0 || busy) && i < 3000) begin
      tick(1);
      i++;
    end
    chk("idle_reached", 32'(i < 3000), 32'd1);
    chk("bus_consumed", 32'(exp_bus.size()), 32'd0);
  endtask
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      bus.tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc_n % 3 == 0) : 1'($urandom_range(0, 1));
    end
  end
  initial begin
    bus.wb_ack = 1'b0;
    bus.wb_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.wb_ack = 1'b0;
      if (!rst_n || !bus.wb_stb) slv_cnt = -1;
      else begin
        if (slv_cnt < 0) slv_cnt = lat_q.size() != 0 ? lat_q.pop_front() : 1000;
        else slv_cnt--;
        if (slv_cnt == 0) begin
          bus.wb_ack = 1'b1;
          bus.wb_dat_i = smem[bus.wb_addr[4:2]];
          if (bus.wb_we) smem[bus.wb_addr[4:2]] = bus.wb_dat_o;
        end
      end
    end
  end
  logic prev_stb = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_tx = 8'h0;
  int stb_len = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("cyc_eq_stb", 32'(bus.wb_cyc), 32'(bus.wb_stb));
      if (bus.wb_stb) begin
        if (!prev_stb) begin
          stb_len = 0;
          chk("stb_expected", 32'(exp_bus.size() != 0), 32'd1);
          if (exp_bus.size() != 0) cur = exp_bus.pop_front();
          got_bus.push_back('{bus.wb_addr, bus.wb_we, bus.wb_dat_o, 1'b0});
        end
        stb_len++;
        chk("wb_addr", bus.wb_addr, cur.a);
        chk("wb_we", 32'(bus.wb_we), 32'(cur.we));
        chk("wb_sel", 32'(bus.wb_sel), 32'hF);
        if (cur.we) chk("wb_dat_o", bus.wb_dat_o, cur.d);
      end else if (prev_stb && cur.noack) chk("stb_len", 32'(stb_len), 32'(BT));
      prev_stb = bus.wb_stb;
      if (prev_stall) begin
        chk("tx_held", 32'(bus.tx_valid), 32'd1);
        chk("tx_stable", 32'(bus.tx_data), 32'(prev_tx));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
        got_tx.push_back(bus.tx_data);
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_tx = bus.tx_data;
    end
  end
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    logic [7:0] c;
    logic [31:0] a;
    int lat;
    int n;
    logic [7:0] rd_exp [5];
    rd_exp[0] = 8'h06;
    rd_exp[1] = 8'h12;
    rd_exp[2] = 8'h34;
    rd_exp[3] = 8'h56;
    rd_exp[4] = 8'h78;
    bus.rx_data = 8'h0;
    bus.rx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smem[k] = 32'h0;
      mmem[k] = 32'h0;
    end
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_stb", 32'(bus.wb_stb), 32'd0);
    chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("rst_we", 32'(bus.wb_we), 32'd0);
    chk("rst_sel", 32'(bus.wb_sel), 32'd0);
    chk("rst_addr", bus.wb_addr, 32'd0);
    chk("rst_dat_o", bus.wb_dat_o, 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick(2);
    send_frame(1'b1, 32'h4, 32'hAA, 2, 0);
    wait_idle();
    chk("wr_addr", got_bus[0].a, 32'h4);
    chk("wr_dat", got_bus[0].d, 32'hAA);
    chk("wr_we", 32'(got_bus[0].we), 32'd1);
    chk("wr_resp", 32'(got_tx[0]), 32'h06);
    chk("wr_slave_mem", smem[1], 32'hAA);
    chk("wr_busy", 32'(busy), 32'd0);
    smem[1] = 32'h12345678;
    mmem[1] = 32'h12345678;
    send_frame(1'b0, 32'h4, 32'h0, 1, 0);
    wait_idle();
    chk("rd_we", 32'(got_bus[1].we), 32'd0);
    for (int k = 0; k < 5; k++) chk("rd_bytes", 32'(got_tx[1+k]), 32'(rd_exp[k]));
    rdy_mode = 1;
    send_frame(1'b0, 32'h4, 32'h0, 0, 2);
    wait_idle();
    rdy_mode = 0;
    chk("stall_count", 32'(got_tx.size()), 32'd11);
    for (int k = 0; k < 5; k++) chk("stall_bytes", 32'(got_tx[6+k]), 32'(rd_exp[k]));
    n = got_bus.size();
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_idle();
    chk("badcmd_nak", 32'(got_tx[11]), 32'h15);
    chk("badcmd_nostb", 32'(got_bus.size()), 32'(n));
    send_frame(1'b0, 32'h8, 32'h0, -1, 1);
    wait_idle();
    chk("timeout_nak", 32'(got_tx[12]), 32'h15);
    chk("timeout_count", 32'(got_tx.size()), 32'd13);
    send_frame(1'b0, 32'h4, 32'h0, BT - 1, 0);
    wait_idle();
    chk("lastcyc_ack", 32'(got_tx[13]), 32'h06);
    chk("lastcyc_count", 32'(got_tx.size()), 32'd18);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    tick(FT + 10);
    chk("partial_busy", 32'(busy), 32'd0);
    chk("partial_silent", 32'(got_tx.size()), 32'd18);
    send_frame(1'b0, 32'h4, 32'h0, 1, 0);
    wait_idle();
    chk("after_partial_ack", 32'(got_tx[18]), 32'h06);
    chk("after_partial_last", 32'(got_tx[22]), 32'h78);
    repeat (60) begin
      rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        do c = 8'($urandom); while (c == 8'h57 || c == 8'h52);
        exp_tx.push_back(8'h15);
        send_byte(c);
      end else begin
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
        lat = $urandom_range(0, 7) == 0 ? -1 : $urandom_range(0, 9) == 0 ? BT - 1 : $urandom_range(0, 3);
        send_frame(1'($urandom_range(0, 1)), a, $urandom, lat, 3);
      end
      wait_idle();
    end
    rdy_mode = 0;
    chk("random_no_overrun", 32'(overrun), 32'd0);
    send_frame(1'b1, 32'h10, 32'h5A5A0F0F, 3, 0);
    send_byte(8'h52);
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_idle();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("overrun_slave_mem", smem[4], 32'h5A5A0F0F);
    send_frame(1'b0, 32'h0, 32'h0, -1, 0);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stb", 32'(bus.wb_stb), 32'd0);
    chk("arst_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    exp_tx.delete();
    exp_bus.delete();
    lat_q.delete();
    n = got_tx.size();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("arst_silent", 32'(got_tx.size()), 32'(n));
    send_frame(1'b1, 32'h8, 32'hCAFE0001, 0, 1);
    wait_idle();
    send_frame(1'b0, 32'h8, 32'h0, 2, 1);
    wait_idle();
    chk("post_rst_last", 32'(got_tx[got_tx.size()-1]), 32'h01);
    chk("post_rst_overrun", 32'(overrun), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
Host debug bridge and Wishbone initiator that drives the SoC peripheral bus (uart, pwm, etc.) from a serial byte stream. It takes command bytes from a UART receiver byte interface, decodes single-word read/write frames and issues one Wishbone classic transfer per frame. It returns a status byte, plus data bytes for reads, on a UART transmitter byte interface. It sits between the debug UART byte layer and the bus interconnect, in parallel with the CPU master.

Parameters:
ADDR_WIDTH, 32, Wishbone address width (frame always carries 4 address bytes; upper bits truncated)
BUS_TIMEOUT, 1024, max cycles stb held without ack before abort
FRAME_TIMEOUT, 500000, max idle cycles between bytes of one frame before discard (10 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe: rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter can take a byte; transfer when tx_valid && tx_ready
wb_addr  out  ADDR_WIDTH  bus address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_we  out  1  write enable
wb_sel  out  4  byte select, always 4'hF during a transfer
wb_stb  out  1  strobe
wb_cyc  out  1  cycle, identical to wb_stb
wb_ack  in  1  slave acknowledge
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: byte dropped while not accepting; cleared by reset only

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Applies asynchronously, mid-frame or mid-transfer included. wb_stb/cyc drop immediately and no response is sent.
- Frame format (multi-byte fields MSB first):
  - Write: 0x57 ('W'), A3..A0, D3..D0.
  - Read: 0x52 ('R'), A3..A0.
- Responses:
  - 0x06 ACK; a read ACK is followed by 4 data bytes, MSB first.
  - 0x15 NAK.
- States: IDLE, GET_ADDR, GET_DATA, BUS, RESP_STATUS, RESP_DATA.
- IDLE, on rx_valid:
  - 0x57 or 0x52: latch we, go to GET_ADDR with byte count 0.
  - Any other byte: load NAK, go to RESP_STATUS.
- GET_ADDR: shift each byte into addr. After the 4th byte go to GET_DATA (write) or BUS (read).
- GET_DATA: shift 4 bytes into wdata, then go to BUS.
- Frame timeout:
  - The idle counter runs in GET_ADDR/GET_DATA and resets on every rx_valid.
  - At FRAME_TIMEOUT it discards the frame, returns to IDLE and sends no response.
- BUS:
  - wb_stb/wb_cyc/wb_sel/wb_we/wb_addr/wb_dat_o are registered and asserted the cycle after the last frame byte is accepted.
  - They are held stable until wb_ack is sampled high.
  - On that edge: deassert stb/cyc, capture wb_dat_i when reading, load ACK, go to RESP_STATUS.
  - Minimum ack latency 1 cycle; an ack present in the first stb cycle is honoured.
- Bus timeout:
  - If BUS_TIMEOUT cycles elapse in BUS with no ack: deassert stb/cyc, load NAK, go to RESP_STATUS.
  - No data bytes follow this NAK, even for a read.
  - An ack arriving in the same cycle the counter expires wins, and the response is ACK.
- RESP_STATUS:
  - tx_valid=1, tx_data=status.
  - On handshake: go to RESP_DATA if this is a read ACK, else go to IDLE.
- RESP_DATA: send rdata[31:24], [23:16], [15:8], [7:0]; each byte waits for its own handshake; then go to IDLE.
- tx_data is stable while tx_valid=1 and !tx_ready. tx_valid deasserts the cycle after the final handshake.
- Bytes are accepted only in IDLE/GET_ADDR/GET_DATA. rx_valid in BUS/RESP_* drops the byte and sets overrun.
- Throughput: back-to-back rx_valid on consecutive cycles is accepted in all receiving states.

Test Plan:
- Write frame 57 00 00 00 04 00 00 00 AA, slave acks 2 cycles after stb -> one transfer addr=0x04, dat_o=0x000000AA, we=1, sel=F; tx byte 0x06; busy low afterwards.
- Read frame 52 00 00 00 04, slave returns 0x12345678 with ack -> we=0; tx bytes 06 12 34 56 78 in order.
- tx_ready toggled 1-of-3 cycles during a read response -> same 5 bytes, no duplicates or losses, tx_data stable while stalled.
- Command 0x41 -> tx 0x15 only, no stb. Read frame with slave never acking -> stb high for exactly BUS_TIMEOUT cycles, then tx 0x15 only.
- Send 57 00 00, wait FRAME_TIMEOUT+10 idle cycles, then a full read frame -> no response to the partial frame, read completes normally.
- Extra rx byte injected during BUS -> overrun=1, transfer result unchanged. rst_n pulsed low during BUS -> stb/cyc/tx_valid 0 immediately, next frame works and overrun=0.
